// File: rtl/if_types_pkg.sv
// Shared types for the cache front end: interface FSM states, cache opcodes,
// register offsets, STATUS bit positions and a byte-enable merge helper.
package if_types_pkg;

  typedef enum logic [1:0] {
    IF_ST_IDLE     = 2'd0,
    IF_ST_WAIT     = 2'd1,
    IF_ST_COMPLETE = 2'd2
  } if_state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_GET = 2'd1,
    OP_PUT = 2'd2,
    OP_DEL = 2'd3
  } cache_op_e;

  localparam logic [2:0] REG_OP        = 3'd0;
  localparam logic [2:0] REG_KEY       = 3'd1;
  localparam logic [2:0] REG_VALUE_IN  = 3'd2;
  localparam logic [2:0] REG_VALUE_OUT = 3'd3;
  localparam logic [2:0] REG_STATUS    = 3'd4;

  localparam int STATUS_STATE_LSB   = 0;
  localparam int STATUS_HIT_BIT     = 2;
  localparam int STATUS_DONE_BIT    = 3;
  localparam int STATUS_TIMEOUT_BIT = 4;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/obi_cache_if_regs.sv
// Register file slice of the cache front end: address decode, byte-enable merge,
// read mux, error generation and the registered OBI response.
module obi_cache_if_regs
  import if_types_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  input  logic              wr_lock,
  input  cache_op_e         op_cur,
  input  logic [31:0]       value_out,
  input  logic [31:0]       status,
  output logic              op_wr,
  output cache_op_e         op_wdata,
  output logic              status_rd,
  output logic [31:0]       key,
  output logic [31:0]       value_in,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              err
);

  logic [2:0]  offset;
  logic        key_wr;
  logic        value_in_wr;
  logic        acc_err;
  logic [31:0] rd_mux;
  logic        unused_addr_bits;

  assign offset           = addr[4:2];
  assign op_wdata         = cache_op_e'(wdata[1:0]);
  assign unused_addr_bits = ^{addr[ADDR_W-1:5], addr[1:0], wdata[31:2] & {30{1'b0}}};

  // Writes to OP/KEY/VALUE_IN are refused while an operation is in flight.
  always_comb begin
    op_wr       = 1'b0;
    key_wr      = 1'b0;
    value_in_wr = 1'b0;
    status_rd   = 1'b0;
    acc_err     = 1'b0;
    rd_mux      = '0;
    if (req) begin
      case (offset)
        REG_OP: begin
          if (we) begin
            if (wr_lock) acc_err = 1'b1;
            else         op_wr   = be[0];
          end else begin
            rd_mux = {30'd0, op_cur};
          end
        end
        REG_KEY: begin
          if (we) begin
            if (wr_lock) acc_err = 1'b1;
            else         key_wr  = 1'b1;
          end else begin
            rd_mux = key;
          end
        end
        REG_VALUE_IN: begin
          if (we) begin
            if (wr_lock) acc_err     = 1'b1;
            else         value_in_wr = 1'b1;
          end else begin
            rd_mux = value_in;
          end
        end
        REG_VALUE_OUT: begin
          if (we) acc_err = 1'b1;
          else    rd_mux  = value_out;
        end
        REG_STATUS: begin
          if (we) begin
            acc_err = 1'b1;
          end else begin
            rd_mux    = status;
            status_rd = 1'b1;
          end
        end
        default: acc_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key      <= '0;
      value_in <= '0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      err      <= 1'b0;
    end else begin
      if (key_wr)      key      <= be_merge(key, wdata, be);
      if (value_in_wr) value_in <= be_merge(value_in, wdata, be);
      rvalid <= req;
      rdata  <= rd_mux;
      err    <= acc_err;
    end
  end

endmodule

// File: rtl/obi_cache_if.sv
// OBI subordinate front end of the Redis cache: runs the IDLE/WAIT/COMPLETE FSM
// and the start/done handshake. Optional WAIT timeout enabled by IF_TIMEOUT_EN.
module obi_cache_if
  import if_types_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              obi_req_i,
  output logic              obi_gnt_o,
  input  logic [ADDR_W-1:0] obi_addr_i,
  input  logic              obi_we_i,
  input  logic [3:0]        obi_be_i,
  input  logic [31:0]       obi_wdata_i,
  output logic              obi_rvalid_o,
  output logic [31:0]       obi_rdata_o,
  output logic              obi_err_o,
  output logic              ctrl_start_o,
  output logic [1:0]        ctrl_op_o,
  output logic [31:0]       ctrl_key_o,
  output logic [31:0]       ctrl_value_o,
  input  logic              ctrl_done_i,
  input  logic              ctrl_hit_i,
  input  logic [31:0]       ctrl_rdata_i
);

  if_state_e   state, state_next;
  cache_op_e   op_q, op_wdata;
  logic [31:0] value_out_q;
  logic [31:0] status_word;
  logic        hit_q, done_flag_q, timeout_q, expire;
  logic        op_wr, status_rd;
  logic        start_evt, done_evt, timeout_evt, clr_done;

  assign obi_gnt_o = obi_req_i;
  assign ctrl_op_o = op_q;

  always_comb begin
    status_word                                  = '0;
    status_word[STATUS_STATE_LSB +: 2]           = state;
    status_word[STATUS_HIT_BIT]                  = hit_q;
    status_word[STATUS_DONE_BIT]                 = done_flag_q;
    status_word[STATUS_TIMEOUT_BIT]              = timeout_q;
  end

  obi_cache_if_regs #(.ADDR_W(ADDR_W)) u_regs (
    .clk       (clk),
    .rst       (rst),
    .req       (obi_req_i),
    .addr      (obi_addr_i),
    .we        (obi_we_i),
    .be        (obi_be_i),
    .wdata     (obi_wdata_i),
    .wr_lock   (state == IF_ST_WAIT),
    .op_cur    (op_q),
    .value_out (value_out_q),
    .status    (status_word),
    .op_wr     (op_wr),
    .op_wdata  (op_wdata),
    .status_rd (status_rd),
    .key       (ctrl_key_o),
    .value_in  (ctrl_value_o),
    .rvalid    (obi_rvalid_o),
    .rdata     (obi_rdata_o),
    .err       (obi_err_o)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IF_ST_IDLE;
    else     state <= state_next;
  end

  // A done pulse only counts in WAIT; when it coincides with expiry, done wins.
  always_comb begin
    state_next  = state;
    start_evt   = 1'b0;
    done_evt    = 1'b0;
    timeout_evt = 1'b0;
    clr_done    = 1'b0;
    case (state)
      IF_ST_IDLE: begin
        if (op_wr && op_wdata != OP_NOP) begin
          start_evt  = 1'b1;
          state_next = IF_ST_WAIT;
        end
      end
      IF_ST_WAIT: begin
        if (ctrl_done_i) begin
          done_evt   = 1'b1;
          state_next = IF_ST_COMPLETE;
        end else if (expire) begin
          timeout_evt = 1'b1;
          state_next  = IF_ST_COMPLETE;
        end
      end
      IF_ST_COMPLETE: begin
        if (op_wr && op_wdata != OP_NOP) begin
          start_evt  = 1'b1;
          state_next = IF_ST_WAIT;
        end else if (status_rd) begin
          clr_done   = 1'b1;
          state_next = IF_ST_IDLE;
        end
      end
      default: state_next = IF_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= OP_NOP;
      value_out_q  <= '0;
      hit_q        <= 1'b0;
      done_flag_q  <= 1'b0;
      ctrl_start_o <= 1'b0;
    end else begin
      ctrl_start_o <= start_evt;
      if (op_wr) op_q <= op_wdata;
      if (start_evt || clr_done) done_flag_q <= 1'b0;
      if (done_evt) begin
        hit_q       <= ctrl_hit_i;
        done_flag_q <= 1'b1;
        if (op_q == OP_GET) value_out_q <= ctrl_rdata_i;
      end else if (timeout_evt) begin
        hit_q       <= 1'b0;
        done_flag_q <= 1'b1;
      end
    end
  end

`ifdef IF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Expiry fires on the WAIT cycle whose increment would reach TIMEOUT_CYCLES.
  assign expire = (state == IF_ST_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (start_evt) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IF_ST_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
      if (timeout_evt)         timeout_q <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign expire    = 1'b0;
  assign timeout_q = 1'b0;
`endif

endmodule
